// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among CHANNELS requesters.
// Each access walks IDLE -> ISSUE -> DONE; an optional timeout turns a missing ack into an error.
module mem_arbiter #(
  parameter int CHANNELS  = 2,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int TIMEOUT   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            req_ren,
  input  logic [CHANNELS-1:0]            req_wen,
  input  logic [CHANNELS*ADDR_BITS-1:0]  req_addr,
  input  logic [CHANNELS*DATA_BITS-1:0]  req_dout,
  output logic [DATA_BITS-1:0]           req_din,
  output logic [CHANNELS-1:0]            req_stall,
  output logic [CHANNELS-1:0]            req_ack,
  output logic [CHANNELS-1:0]            req_err,
  output logic                           mem_cs,
  output logic                           mem_ren,
  output logic                           mem_we,
  output logic [ADDR_BITS-1:0]           mem_addr,
  output logic [DATA_BITS-1:0]           mem_din,
  input  logic [DATA_BITS-1:0]           mem_dout,
  input  logic                           mem_ack
);

  localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [GW-1:0] LAST_RST  = GW'(CHANNELS - 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  logic [1:0]           state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_q, last_d;
  logic [CW-1:0]        wait_q, wait_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [CHANNELS-1:0]  pending;
  logic [GW-1:0]        rr_pick;
  logic                 rr_found;
  logic [GW-1:0]        idx;

  logic [ADDR_BITS-1:0] addr_a [CHANNELS];
  logic [DATA_BITS-1:0] dout_a [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign addr_a[g] = req_addr[g*ADDR_BITS +: ADDR_BITS];
    assign dout_a[g] = req_dout[g*DATA_BITS +: DATA_BITS];
  end

  assign pending = req_ren | req_wen;

  // Search starts one past the last winner so the previous grantee is considered last.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    rr_pick  = last_q;
    rr_found = 1'b0;
    idx      = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = GW'((int'(last_q) + k) % CHANNELS);
      if (!rr_found && pending[idx]) begin
        rr_found = 1'b1;
        rr_pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_pick;
          last_d  = rr_pick;
          wait_d  = '0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // An ack arriving on the final wait cycle still wins over the timeout.
        if (mem_ack) begin
          rdata_d = mem_dout;
          err_d   = 1'b0;
          state_d = DONE;
        end else if ((TIMEOUT > 0) && (wait_q == TIMEOUT_C)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      wait_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory side follows the live inputs of the granted channel.
  always_comb begin
    mem_cs   = (state_q == ISSUE);
    mem_we   = mem_cs & req_wen[grant_q];
    mem_ren  = mem_cs & req_ren[grant_q] & ~req_wen[grant_q];
    mem_addr = addr_a[grant_q];
    mem_din  = dout_a[grant_q];
  end

  always_comb begin
    req_ack = '0;
    req_err = '0;
    req_din = '0;
    if (state_q == DONE) begin
      req_ack[grant_q] = 1'b1;
      req_err[grant_q] = err_q;
      req_din          = rdata_q;
    end
  end

  assign req_stall = pending & ~req_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected completions and memory
// transactions; a memory model and a completion monitor pop and compare them.
module tb_mem_arbiter;

  localparam int CH = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    bit          ren;
    logic [31:0] din;
    int          lat;
    logic [31:0] rdata;
    int          cs_cycles;
  } mem_item_t;

  typedef struct {
    int          ch;
    logic [31:0] din;
    bit          err;
    int          cycle;
  } sb_item_t;

  logic               clk;
  logic               rst;
  logic [CH-1:0]      req_ren, req_wen;
  logic [CH*AW-1:0]   req_addr;
  logic [CH*DW-1:0]   req_dout;
  logic [DW-1:0]      req_din;
  logic [CH-1:0]      req_stall, req_ack, req_err;
  logic               mem_cs, mem_ren, mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_din;
  logic [DW-1:0]      mem_dout;
  logic               mem_ack;

  mem_arbiter #(
    .CHANNELS(CH), .ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_dout(req_dout),
    .req_din(req_din), .req_stall(req_stall), .req_ack(req_ack), .req_err(req_err),
    .mem_cs(mem_cs), .mem_ren(mem_ren), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  mem_item_t mem_q[$];
  sb_item_t  sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory model: acks after cur.lat wait cycles (never if negative).
  initial begin
    mem_item_t cur;
    bit        busy;
    int        cs_cnt;
    busy = 1'b0;
    cs_cnt = 0;
    cur = '{32'h0, 1'b0, 1'b0, 32'h0, -1, 32'h0, 0};
    mem_ack = 1'b0;
    mem_dout = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_cs) begin
        if (!busy) begin
          busy = 1'b1;
          cs_cnt = 0;
          if (mem_q.size() == 0) begin
            check("mem_unexpected_cs", {31'h0, mem_cs}, 32'h0);
            cur = '{32'h0, 1'b0, 1'b0, 32'h0, -1, 32'h0, 0};
          end else begin
            cur = mem_q.pop_front();
            check("mem_addr", mem_addr, cur.addr);
            check("mem_we", {31'h0, mem_we}, {31'h0, cur.we});
            check("mem_ren", {31'h0, mem_ren}, {31'h0, cur.ren});
            if (cur.we) check("mem_din", mem_din, cur.din);
          end
        end
        if (cur.lat >= 0 && cs_cnt == cur.lat) begin
          mem_ack = 1'b1;
          mem_dout = cur.rdata;
        end
        cs_cnt++;
      end else if (busy) begin
        busy = 1'b0;
        check("mem_cs_cycles", cs_cnt, cur.cs_cycles);
      end
    end
  end

  // Completion monitor.
  initial begin
    sb_item_t e;
    forever begin
      @(negedge clk);
      if (|req_ack) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ack", {30'h0, req_ack}, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("ack_vec", {30'h0, req_ack}, 32'(1) << e.ch);
          check("ack_din", req_din, e.din);
          check("ack_err", {30'h0, req_err}, e.err ? (32'(1) << e.ch) : 32'h0);
          check("ack_cycle", cyc, e.cycle);
          check("ack_stall_low", {31'h0, req_stall[e.ch]}, 32'h0);
        end
      end else if (|req_err) begin
        check("spurious_err", {30'h0, req_err}, 32'h0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic access(input int ch, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input logic [31:0] rdata, input int cs_cyc,
                        input int done_off, input logic [31:0] exp_din, input bit exp_err);
    int n;
    mem_q.push_back('{addr, wr, rd && !wr, wdata, lat, rdata, cs_cyc});
    sb_q.push_back('{ch, exp_din, exp_err, cyc + done_off});
    req_ren[ch] = rd;
    req_wen[ch] = wr;
    req_addr[ch*AW +: AW] = addr;
    req_dout[ch*DW +: DW] = wdata;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (!req_stall[ch]) break;
      n++;
    end
    check($sformatf("stall_cycles_ch%0d", ch), n, done_off);
    @(posedge clk); #1;
    req_ren[ch] = 1'b0;
    req_wen[ch] = 1'b0;
  endtask

  initial begin
    int          t;
    logic [1:0]  exp_stall;
    rst = 1'b1;
    req_ren = '0;
    req_wen = '0;
    req_addr = '0;
    req_dout = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_mem_cs", {31'h0, mem_cs}, 32'h0);
    check("rst_mem_ren", {31'h0, mem_ren}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_req_ack", {30'h0, req_ack}, 32'h0);
    check("rst_req_din", req_din, 32'h0);
    check("rst_req_stall", {30'h0, req_stall}, 32'h0);
    @(posedge clk); #1;

    // Single read, zero-wait memory.
    access(0, 1, 0, 32'h40, 32'h0, 0, 32'hDEADBEEF, 1, 2, 32'hDEADBEEF, 0);
    // Write priority when both ren and wen are set.
    access(1, 1, 1, 32'h80, 32'h12345678, 0, 32'h0, 1, 2, 32'h0, 0);

    // Round-robin contention: both hold requests; last grant was channel 1.
    t = cyc;
    mem_q.push_back('{32'h100, 1'b0, 1'b1, 32'h0, 0, 32'h11110001, 1});
    mem_q.push_back('{32'h200, 1'b0, 1'b1, 32'h0, 0, 32'h22220002, 1});
    mem_q.push_back('{32'h100, 1'b0, 1'b1, 32'h0, 0, 32'h11110003, 1});
    mem_q.push_back('{32'h200, 1'b0, 1'b1, 32'h0, 0, 32'h22220004, 1});
    sb_q.push_back('{0, 32'h11110001, 1'b0, t + 2});
    sb_q.push_back('{1, 32'h22220002, 1'b0, t + 5});
    sb_q.push_back('{0, 32'h11110003, 1'b0, t + 8});
    sb_q.push_back('{1, 32'h22220004, 1'b0, t + 11});
    req_ren = 2'b11;
    req_addr = {32'h200, 32'h100};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_stall = (k == 2 || k == 8) ? 2'b10 : (k == 5 || k == 11) ? 2'b01 : 2'b11;
      check($sformatf("rr_stall_k%0d", k), {30'h0, req_stall}, {30'h0, exp_stall});
    end
    @(posedge clk); #1;
    req_ren = 2'b00;

    // Three memory wait states.
    access(0, 1, 0, 32'h300, 32'h0, 3, 32'hCAFEF00D, 4, 5, 32'hCAFEF00D, 0);
    // Memory never acks: timeout after 5 ISSUE cycles.
    access(1, 1, 0, 32'h400, 32'h0, -1, 32'h0, 5, 6, 32'h0, 1);
    // Ack on the fifth ISSUE cycle is a normal completion.
    access(0, 1, 0, 32'h500, 32'h0, 4, 32'h55AA55AA, 5, 6, 32'h55AA55AA, 0);
    // Write-only with one wait state.
    access(1, 0, 1, 32'h600, 32'hA0A0A0A0, 1, 32'h0BADF00D, 2, 3, 32'h0BADF00D, 0);

    // Reset during ISSUE of a channel-0 access that memory never acks.
    mem_q.push_back('{32'h700, 1'b0, 1'b1, 32'h0, -1, 32'h0, 2});
    req_ren[0] = 1'b1;
    req_addr[0 +: AW] = 32'h700;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    req_ren[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    t = cyc;
    mem_q.push_back('{32'h800, 1'b0, 1'b1, 32'h0, 0, 32'h80808080, 1});
    mem_q.push_back('{32'h900, 1'b0, 1'b1, 32'h0, 0, 32'h90909090, 1});
    sb_q.push_back('{0, 32'h80808080, 1'b0, t + 2});
    sb_q.push_back('{1, 32'h90909090, 1'b0, t + 5});
    req_ren = 2'b11;
    req_addr = {32'h900, 32'h800};
    @(negedge clk);
    check("post_rst_mem_cs", {31'h0, mem_cs}, 32'h0);
    for (int k = 1; k < 6; k++) @(negedge clk);
    @(posedge clk); #1;
    req_ren = 2'b00;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_leftover", sb_q.size(), 32'h0);
    check("mem_leftover", mem_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-channel arbiter that lets several requesters share one single-port memory (`data_ram`-style: `cs`/`ren`/`we`/`addr`/`din`/`dout`/`ack`). It replaces the fixed one-memory-per-port hookup in the CPU wrapper. Instruction fetch, data access and later a cache refill engine can share one memory behind round-robin arbitration. Each requester keeps the core's stall semantics: it holds its request while its stall is high and advances when stall drops. A configurable timeout turns a missing memory `ack` into an error completion.

## Interface
- `CHANNELS`, 2: number of requesters, ≥2.
- `ADDR_BITS`, 32: address width per channel.
- `DATA_BITS`, 32: data width.
- `TIMEOUT`, 0: cycles to wait for `mem_ack` after issue. 0 disables the timeout.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_ren`  in  CHANNELS  read request per channel.
- `req_wen`  in  CHANNELS  write request per channel.
- `req_addr`  in  CHANNELS*ADDR_BITS  channel i at `[i*ADDR_BITS +: ADDR_BITS]`.
- `req_dout`  in  CHANNELS*DATA_BITS  write data, same packing.
- `req_din`  out  DATA_BITS  read data, broadcast to all channels, valid with `req_ack`.
- `req_stall`  out  CHANNELS  requester must hold its request while high.
- `req_ack`  out  CHANNELS  one-cycle completion pulse.
- `req_err`  out  CHANNELS  one-cycle pulse with `req_ack` when the access timed out.
- `mem_cs`, `mem_ren`, `mem_we`  out  1  memory controls.
- `mem_addr`  out  ADDR_BITS  memory address.
- `mem_din`  out  DATA_BITS  memory write data.
- `mem_dout`  in  DATA_BITS  memory read data, valid when `mem_ack`=1.
- `mem_ack`  in  1  memory completion, one cycle.

## Operation
- **Pending request:** channel i is pending when `req_ren[i] | req_wen[i]`. If both are set, the access is a write (`mem_we`=1, `mem_ren`=0).
- **States:**
  - IDLE:
    - If any channel is pending, pick one round-robin, searching from `last+1` mod CHANNELS upward.
    - Register `grant` and `last`, and go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - Drive `mem_cs`=1 and pass the granted channel's `addr`/`dout`/`ren`/`we` through combinationally.
    - On `mem_ack`: capture `mem_dout` into `rdata` and go to DONE.
    - If `TIMEOUT`>0 and the wait counter reaches `TIMEOUT` without `mem_ack`: set `rdata`=0 and `err`, then go to DONE.
  - DONE (exactly one cycle):
    - `req_ack[grant]`=1.
    - `req_err[grant]`=`err`.
    - `req_din`=`rdata`.
    - Then go to IDLE.
- **Stall:** `req_stall[i]` = pending(i) AND NOT (state==DONE AND grant==i). This is combinational from the request inputs.
- **Memory-side outputs outside ISSUE:** `mem_cs`/`mem_ren`/`mem_we`=0. `mem_addr`/`mem_din` are don't-care but are driven from channel `grant`.
- **Wait counter:** width `$clog2(TIMEOUT+1)`. Cleared on entry to ISSUE, increments each ISSUE cycle without `mem_ack`. `mem_ack` in the same cycle the counter hits `TIMEOUT` counts as a normal completion, not an error.
- **Mid-access request changes:** a requester that drops or changes its request during ISSUE is a protocol violation. The arbiter still completes on the latched `grant` and pulses that channel's `req_ack`; `mem_*` follow the live inputs.
- **Reset values:** state IDLE, `last`=CHANNELS-1 (channel 0 wins first), `grant`=0, `rdata`=0, `err`=0. `req_ack`, `req_err`, `req_din`, `mem_cs`, `mem_ren` and `mem_we` are all 0. `req_stall` follows its equation.
- **Reset mid-access:** the access is abandoned with no `req_ack`, and the memory controls drop in the cycle after the reset edge.

## Timing
- **Latency:** request first seen in IDLE at cycle t → ISSUE at t+1 → memory acks at t+1+L (L≥0 wait cycles) → DONE at t+2+L. `req_stall` is high from t through t+1+L and low at t+2+L.
- **Turnaround:** the requester advances on the DONE edge. IDLE always occupies at least one cycle between accesses, so a channel's old request held during DONE is never re-granted.
- **Throughput:** with zero-wait memory (`mem_ack` in the first ISSUE cycle), one access every 3 cycles. No two consecutive grants go to the same channel while another channel is pending.
- **Ack alignment:** `req_ack`, `req_err` and `req_din` are registered and valid only in DONE.

## Test plan
- **Single read:** reset, then channel 0 reads 0x40 with `mem_ack` in the first ISSUE cycle and `mem_dout`=0xDEADBEEF → `mem_cs` high for 1 cycle; `req_ack[0]` and `req_din`=0xDEADBEEF at cycle 3; `req_stall[0]` high for cycles 1–2.
- **Round-robin contention:** both channels request continuously → grants alternate 0,1,0,1; each channel's stall drops only in its own DONE cycle.
- **Write priority:** `req_ren` and `req_wen` both high, `req_dout`=0x12345678 → `mem_we`=1, `mem_ren`=0, `mem_din`=0x12345678.
- **Timeout:** `TIMEOUT`=4, memory never acks → `mem_cs` high for 5 cycles, then `req_ack` and `req_err` pulse with `req_din`=0. Ack on the 5th ISSUE cycle → no error.
- **Memory wait states:** `mem_ack` delayed 3 cycles → DONE occurs 5 cycles after the request is first seen.
- **Reset mid-ISSUE:** assert `rst` during ISSUE → no `req_ack`; next cycle `mem_cs`=0; the first grant after reset goes to channel 0.
